dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-ported data memory between two requesters: the pipeline Memory stage (CPU port) and a debug/loader master (DBG port).
- Sequences each access through a small FSM, honouring a fixed memory read latency.
- Stalls the CPU pipeline while its access is outstanding.
- Bounds debug starvation with a fairness counter.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from the memory issue cycle to valid mem_rdata; must be >= 1.
- STARVE_MAX, 4, maximum consecutive CPU grants while dbg_req is pending; must be >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: one clock; reset is synchronous and active-high.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_stall  out  1  freeze pipeline.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data, valid with cpu_ack.
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug request, same rules as the CPU port.
- dbg_ack  out  1  debug completion pulse.
- dbg_rdata  out  DATA_W  debug read data, valid with dbg_ack.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset: state=IDLE; owner, starve_cnt and the latency counter cleared.
  - All outputs 0, including rdata registers and cpu_stall; any in-flight access is discarded and no ack is issued.
- States and transitions:
  - IDLE -> ISSUE on any request.
  - ISSUE -> RESP for a write; ISSUE -> WAIT for a read.
  - WAIT -> RESP after the latency counter expires.
  - RESP -> IDLE unconditionally.
- Arbitration in IDLE:
  - Grant DBG if dbg_req && (!cpu_req || starve_cnt==STARVE_MAX).
  - Otherwise grant CPU if cpu_req.
  - On the IDLE->ISSUE edge, latch owner, we, addr and wdata.
- starve_cnt:
  - Increments on each CPU grant made while dbg_req=1.
  - Clears on a DBG grant, or on a CPU grant made while dbg_req=0.
  - Never exceeds STARVE_MAX.
- ISSUE (1 cycle): mem_en=1, mem_we=latched we, mem_addr and mem_wdata driven from latched values. mem_en=0 and mem_we=0 in every other state.
- Read timing:
  - ISSUE in cycle N; mem_rdata is valid in cycle N+MEM_LAT and is captured at the end of that cycle.
  - RESP in cycle N+MEM_LAT+1.
  - WAIT lasts MEM_LAT cycles; the counter loads MEM_LAT-1 at ISSUE and counts down to 0.
- RESP (1 cycle):
  - The owner's ack=1; the owner's rdata is updated for reads and holds its previous value for writes.
  - The non-owner's rdata holds.
- Latency: write = 3 cycles (IDLE, ISSUE, RESP); read = MEM_LAT+3 cycles.
- cpu_stall = cpu_req && !(state==RESP && owner==CPU). This is combinational from registered state plus cpu_req, and is asserted while DBG owns the memory.
- Request rules:
  - A requester keeps req and its fields stable until ack.
  - A req still high in the cycle after ack is a new request.
  - Requests are never dropped or merged.
- Input changes while the FSM is not in IDLE have no effect on the current transaction.
- rst asserted in any state: the next state is IDLE regardless of pending requests.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- Defined:
  - Adds output port cpu_stall_cnt [15:0], counting cycles with cpu_stall=1.
  - Saturates at 16'hFFFF and is cleared by rst.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. CPU read alone, MEM_LAT=2: cpu_req=1, we=0, addr=0x10 at t0; memory returns 0xDEADBEEF at t3 -> mem_en=1 and mem_addr=0x10 at t1; cpu_ack=1 with cpu_rdata=0xDEADBEEF at t4; cpu_stall=1 for t0..t3 and 0 at t4.
2. CPU write addr=0x20, wdata=0x1234 at t0 -> mem_en=1, mem_we=1, mem_addr=0x20, mem_wdata=0x1234 at t1; cpu_ack at t2; cpu_stall=1 for t0..t1.
3. cpu_req and dbg_req (read, addr 0x40) both rise at t0 with starve_cnt=0 -> CPU write is served first (ack t2); DBG issues at t4; dbg_ack at t7 with dbg_rdata=mem value; cpu_stall stays 0 after t2 if cpu_req drops.
4. Starvation, STARVE_MAX=4: back-to-back CPU writes with dbg_req (write) held from t0 -> CPU acks at t2, t5, t8, t11; DBG ISSUE at t13, dbg_ack at t14; cpu_stall=1 for t12..t14; the next CPU grant is at t15.
5. rst=1 at t2 during a CPU read in WAIT -> at t3: state IDLE, mem_en=0, cpu_ack=0, cpu_stall=0; no ack at t4; a fresh request after rst is served normally.
6. With DMEM_ARB_PERF_EN defined, run scenario 1 -> cpu_stall_cnt=4 at t5; force 70000 stall cycles -> cpu_stall_cnt holds 0xFFFF.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-master (CPU pipeline / debug loader) arbiter in front of a single-ported data memory.
// Optional macro DMEM_ARB_PERF_EN adds the cpu_stall_cnt stall-cycle counter output.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [15:0]       cpu_stall_cnt
`endif
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW    = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;      // 1 = DBG owns the transaction
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  lat_q, lat_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              grant_dbg;

  assign grant_dbg = dbg_req && (!cpu_req || (starve_q == SW'(STARVE_MAX)));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lat_d       = lat_q;
    starve_d    = starve_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (grant_dbg) begin
          state_d  = S_ISSUE;
          owner_d  = 1'b1;
          we_d     = dbg_we;
          addr_d   = dbg_addr;
          wdata_d  = dbg_wdata;
          starve_d = '0;
        end else if (cpu_req) begin
          state_d  = S_ISSUE;
          owner_d  = 1'b0;
          we_d     = cpu_we;
          addr_d   = cpu_addr;
          wdata_d  = cpu_wdata;
          // A CPU grant with DBG waiting counts toward the starvation bound.
          starve_d = dbg_req ? starve_q + SW'(1) : '0;
        end
      end
      S_ISSUE: begin
        lat_d   = CNT_W'(MEM_LAT - 1);
        state_d = we_q ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (lat_q == '0) begin
          // mem_rdata is valid this cycle; register it so it is visible with the ack.
          state_d = S_RESP;
          if (owner_q) dbg_rdata_d = mem_rdata;
          else         cpu_rdata_d = mem_rdata;
        end else begin
          lat_d = lat_q - CNT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lat_q       <= '0;
      starve_q    <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lat_q       <= lat_d;
      starve_q    <= starve_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign mem_en    = (state_q == S_ISSUE);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_ack   = (state_q == S_RESP) && !owner_q;
  assign dbg_ack   = (state_q == S_RESP) && owner_q;
  assign cpu_stall = cpu_req && !cpu_ack;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cpu_stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign cpu_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a per-cycle vector table plus hand-written starvation,
// reset-abort and (with DMEM_ARB_PERF_EN) stall-counter sequences.
module tb_dmem_arbiter;

  logic        clk, rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, mem_rdata;
  logic        cpu_stall, cpu_ack, dbg_ack, mem_en, mem_we;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata;
`ifdef DMEM_ARB_PERF_EN
  logic [15:0] cpu_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .cpu_stall_cnt(cpu_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        creq, cwe;
    logic [31:0] caddr, cwd;
    logic        dreq, dwe;
    logic [31:0] daddr, mrd;
    logic        stall, cack;
    logic [31:0] crd;
    logic        dack;
    logic [31:0] drd;
    logic        men, mwe;
    logic [31:0] maddr, mwd;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] B = 32'h0BAD0BAD;
  localparam logic [31:0] D = 32'hDEADBEEF;
  localparam logic [31:0] C = 32'hCAFEF00D;

  function automatic void add(string nm, logic creq, logic cwe, logic [31:0] caddr, logic [31:0] cwd,
                              logic dreq, logic dwe, logic [31:0] daddr, logic [31:0] mrd,
                              logic est, logic eca, logic [31:0] ecrd, logic eda, logic [31:0] edrd,
                              logic emen, logic emwe, logic [31:0] emaddr, logic [31:0] emwd);
    vec_t v;
    v.name = nm; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.mrd = mrd;
    v.stall = est; v.cack = eca; v.crd = ecrd; v.dack = eda; v.drd = edrd;
    v.men = emen; v.mwe = emwe; v.maddr = emaddr; v.mwd = emwd;
    vecs.push_back(v);
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic creq, logic cwe, logic [31:0] caddr, logic [31:0] cwd,
                       logic dreq, logic dwe, logic [31:0] daddr, logic [31:0] dwd,
                       logic [31:0] mrd);
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    dbg_req = dreq; dbg_we = dwe; dbg_addr = daddr; dbg_wdata = dwd;
    mem_rdata = mrd;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;

    //  name     creq we caddr  cwd      dreq we daddr mrd  stall ack crd  dack drd  men mwe maddr  mwd
    add("rst",    0, 0, 32'h0,  32'h0,    0, 0, 32'h0,  B,   0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0,  32'h0);
    add("s1t0",   1, 0, 32'h10, 32'h0,    0, 0, 32'h0,  B,   1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0,  32'h0);
    add("s1t1",   1, 0, 32'h10, 32'h0,    0, 0, 32'h0,  B,   1, 0, 32'h0, 0, 32'h0, 1, 0, 32'h10, 32'h0);
    add("s1t2",   1, 0, 32'h10, 32'h0,    0, 0, 32'h0,  B,   1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0,  32'h0);
    add("s1t3",   1, 0, 32'h10, 32'h0,    0, 0, 32'h0,  D,   1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0,  32'h0);
    add("s1t4",   1, 0, 32'h10, 32'h0,    0, 0, 32'h0,  B,   0, 1, D,     0, 32'h0, 0, 0, 32'h0,  32'h0);
    add("s1t5",   0, 0, 32'h0,  32'h0,    0, 0, 32'h0,  B,   0, 0, D,     0, 32'h0, 0, 0, 32'h0,  32'h0);
    add("s2t0",   1, 1, 32'h20, 32'h1234, 0, 0, 32'h0,  B,   1, 0, D,     0, 32'h0, 0, 0, 32'h0,  32'h0);
    add("s2t1",   1, 1, 32'h20, 32'h1234, 0, 0, 32'h0,  B,   1, 0, D,     0, 32'h0, 1, 1, 32'h20, 32'h1234);
    add("s2t2",   1, 1, 32'h20, 32'h1234, 0, 0, 32'h0,  B,   0, 1, D,     0, 32'h0, 0, 0, 32'h0,  32'h0);
    add("s2t3",   0, 0, 32'h0,  32'h0,    0, 0, 32'h0,  B,   0, 0, D,     0, 32'h0, 0, 0, 32'h0,  32'h0);
    add("s3t0",   1, 1, 32'h30, 32'h5555, 1, 0, 32'h40, B,   1, 0, D,     0, 32'h0, 0, 0, 32'h0,  32'h0);
    add("s3t1",   1, 1, 32'h30, 32'h5555, 1, 0, 32'h40, B,   1, 0, D,     0, 32'h0, 1, 1, 32'h30, 32'h5555);
    add("s3t2",   1, 1, 32'h30, 32'h5555, 1, 0, 32'h40, B,   0, 1, D,     0, 32'h0, 0, 0, 32'h0,  32'h0);
    add("s3t3",   0, 0, 32'h0,  32'h0,    1, 0, 32'h40, B,   0, 0, D,     0, 32'h0, 0, 0, 32'h0,  32'h0);
    add("s3t4",   0, 0, 32'h0,  32'h0,    1, 0, 32'h40, B,   0, 0, D,     0, 32'h0, 1, 0, 32'h40, 32'h0);
    add("s3t5",   0, 0, 32'h0,  32'h0,    1, 0, 32'h40, B,   0, 0, D,     0, 32'h0, 0, 0, 32'h0,  32'h0);
    add("s3t6",   0, 0, 32'h0,  32'h0,    1, 0, 32'h40, C,   0, 0, D,     0, 32'h0, 0, 0, 32'h0,  32'h0);
    add("s3t7",   0, 0, 32'h0,  32'h0,    1, 0, 32'h40, B,   0, 0, D,     1, C,     0, 0, 32'h0,  32'h0);
    add("s3t8",   0, 0, 32'h0,  32'h0,    0, 0, 32'h0,  B,   0, 0, D,     0, C,     0, 0, 32'h0,  32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwd,
            vecs[i].dreq, vecs[i].dwe, vecs[i].daddr, 32'h0, vecs[i].mrd);
      @(negedge clk);
      check({vecs[i].name, ".cpu_stall"}, 32'(cpu_stall), 32'(vecs[i].stall));
      check({vecs[i].name, ".cpu_ack"},   32'(cpu_ack),   32'(vecs[i].cack));
      check({vecs[i].name, ".cpu_rdata"}, cpu_rdata,      vecs[i].crd);
      check({vecs[i].name, ".dbg_ack"},   32'(dbg_ack),   32'(vecs[i].dack));
      check({vecs[i].name, ".dbg_rdata"}, dbg_rdata,      vecs[i].drd);
      check({vecs[i].name, ".mem_en"},    32'(mem_en),    32'(vecs[i].men));
      check({vecs[i].name, ".mem_we"},    32'(mem_we),    32'(vecs[i].mwe));
      if (vecs[i].men) begin
        check({vecs[i].name, ".mem_addr"},  mem_addr,  vecs[i].maddr);
        check({vecs[i].name, ".mem_wdata"}, mem_wdata, vecs[i].mwd);
      end
      $display("vec %s stall=%0b cack=%0b dack=%0b men=%0b", vecs[i].name, cpu_stall, cpu_ack, dbg_ack, mem_en);
      tick();
    end

    // Starvation: CPU writes back-to-back while a DBG write waits; DBG wins after 4 CPU grants.
    for (int t = 0; t <= 18; t++) begin
      logic creq, dreq, eack, edack, emen;
      creq  = (t <= 17);
      dreq  = (t <= 14);
      eack  = (t == 2) || (t == 5) || (t == 8) || (t == 11) || (t == 17);
      edack = (t == 14);
      emen  = (t == 1) || (t == 4) || (t == 7) || (t == 10) || (t == 13) || (t == 16);
      drive(creq, 1, 32'h70, 32'h77, dreq, 1, 32'h80, 32'h88, B);
      @(negedge clk);
      check($sformatf("s4t%0d.cpu_ack", t),   32'(cpu_ack),   32'(eack));
      check($sformatf("s4t%0d.dbg_ack", t),   32'(dbg_ack),   32'(edack));
      check($sformatf("s4t%0d.mem_en", t),    32'(mem_en),    32'(emen));
      check($sformatf("s4t%0d.cpu_stall", t), 32'(cpu_stall), 32'(creq && !eack));
      if (emen) begin
        check($sformatf("s4t%0d.mem_addr", t),  mem_addr,  (t == 13) ? 32'h80 : 32'h70);
        check($sformatf("s4t%0d.mem_wdata", t), mem_wdata, (t == 13) ? 32'h88 : 32'h77);
      end
      if (edack) check("s4.dbg_rdata_hold", dbg_rdata, C);
      $display("s4 t%0d cack=%0b dack=%0b men=%0b stall=%0b", t, cpu_ack, dbg_ack, mem_en, cpu_stall);
      tick();
    end

    // Reset during a CPU read in WAIT: transaction discarded, then a fresh read is served.
    for (int t = 0; t <= 10; t++) begin
      logic creq, eack;
      logic [31:0] mrd, ecrd;
      creq = (t <= 2) || (t >= 5 && t <= 9);
      mrd  = (t == 8) ? 32'h0000600D : B;
      eack = (t == 9);
      ecrd = (t >= 9) ? 32'h0000600D : 32'h0;
      rst  = (t == 2);
      drive(creq, 0, (t <= 2) ? 32'h50 : 32'h60, 32'h0, 0, 0, 32'h0, 32'h0, mrd);
      @(negedge clk);
      if (t >= 3) begin
        check($sformatf("s5t%0d.cpu_ack", t),   32'(cpu_ack),   32'(eack));
        check($sformatf("s5t%0d.cpu_stall", t), 32'(cpu_stall), 32'(creq && !eack));
        check($sformatf("s5t%0d.mem_en", t),    32'(mem_en),    32'(t == 6));
        check($sformatf("s5t%0d.cpu_rdata", t), cpu_rdata,      ecrd);
        check($sformatf("s5t%0d.dbg_rdata", t), dbg_rdata,      32'h0);
        if (t == 6) check("s5t6.mem_addr", mem_addr, 32'h60);
      end
      $display("s5 t%0d rst=%0b cack=%0b men=%0b stall=%0b rdata=%h", t, rst, cpu_ack, mem_en, cpu_stall, cpu_rdata);
      tick();
    end
    rst = 1'b0;

`ifdef DMEM_ARB_PERF_EN
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, B);
    tick();
    rst = 1'b0;
    for (int t = 0; t <= 5; t++) begin
      drive(t <= 4, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, (t == 3) ? D : B);
      @(negedge clk);
      if (t == 5) check("s6t5.cpu_stall_cnt", 32'(cpu_stall_cnt), 32'd4);
      $display("s6 t%0d stall_cnt=%0d", t, cpu_stall_cnt);
      tick();
    end
    // Continuous CPU reads stall 4 of every 5 cycles: over 70000 stall cycles in 87600.
    drive(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, B);
    repeat (87600) tick();
    @(negedge clk);
    check("s6.cpu_stall_cnt_sat", 32'(cpu_stall_cnt), 32'h0000FFFF);
    $display("s6 saturate stall_cnt=%h", cpu_stall_cnt);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
